// File: rtl/button_pkg.sv
// button_pkg: shared state type and idle pad level for the button debouncer
package button_pkg;
    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE_PRESS,
        PRESSED,
        DEBOUNCE_RELEASE
    } button_state_t;
    // Pad level of a released active-low button; inverted for active-high pads
    localparam logic RELEASED_LEVEL_ACTIVE_LOW = 1'b1;
endpackage

// File: rtl/button_synchronizer.sv
// button_synchronizer: 2-flop synchronizer for an asynchronous pad input
// Ports: clk, reset (async, active high), d (raw pad), q (synchronized level).
// RESET_VALUE sets both flops during reset, normally the pad's idle level.
module button_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounced level, press/release strobes and optional long-press strobe
// Ports: clk, reset (async, active high), button (raw pad), pressed (debounced level),
// press_pulse / release_pulse (one-cycle strobes coincident with pressed changing),
// long_press_pulse (one strobe per press held LONG_PRESS_CYCLES).
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to build the hold counter; otherwise
// long_press_pulse is tied low. DEBOUNCE_CYCLES must be at least 2.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1500000,
    parameter int unsigned LONG_PRESS_CYCLES = 150000000,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic RELEASED_LEVEL = BUTTON_ACTIVE_LOW ? RELEASED_LEVEL_ACTIVE_LOW : ~RELEASED_LEVEL_ACTIVE_LOW;

    button_state_t state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic press_q, press_d, release_q, release_d;
    logic button_sync, s;

    button_synchronizer #(.RESET_VALUE(RELEASED_LEVEL)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button),
        .q     (button_sync)
    );

    assign s       = BUTTON_ACTIVE_LOW ? ~button_sync : button_sync;
    assign cnt_inc = cnt_q + DW'(1);

    // The sample that enters a DEBOUNCE state is the first stable one, so the
    // change is accepted on the edge where the counter reaches DB_LAST.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: if (s) begin
                state_d = DEBOUNCE_PRESS;
                cnt_d   = '0;
            end
            DEBOUNCE_PRESS: if (!s) state_d = IDLE;
                else if (cnt_inc == DB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else cnt_d = cnt_inc;
            PRESSED: if (!s) begin
                state_d = DEBOUNCE_RELEASE;
                cnt_d   = '0;
            end
            DEBOUNCE_RELEASE: if (s) state_d = PRESSED;
                else if (cnt_inc == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else cnt_d = cnt_inc;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed       = (state_q == PRESSED) || (state_q == DEBOUNCE_RELEASE);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic long_q, long_d;

    // The hold count saturates at HOLD_MAX, so HOLD_LAST is passed only once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) hold_d = '0;
        else if (pressed) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_pulse = long_q;
`else
    logic unused_long_press_cycles;
    assign unused_long_press_cycles = ^LONG_PRESS_CYCLES;
    assign long_press_pulse = 1'b0;
`endif
endmodule
